key_map_table: RTL

- Clocked, parametrised key-remapping table that maps each physical note key (one-hot) to a logical note key (one-hot).
- Sits between the keyboard debouncer and the note player / learning logic.
- Adds a command port with write, swap and restore-identity operations.
- Adds a registered read port and error reporting for malformed one-hot operands.

---
 rtl/key_map_table.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/key_map_table.sv
// key_map_table: one-hot physical-to-logical key remapping table.
// Sits between the keyboard debouncer and the note player / learning logic.
// Commands (WRITE, SWAP, CLEAR to identity) arrive on a valid/ready port.
// A registered read port returns the mapping for a one-hot physical key.
//
// Optional feature macro: KEY_MAP_PERM_CHECK_EN
//   When defined, a WRITE whose data already sits in another entry is
//   rejected, so the table always stays a permutation.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready high only in IDLE)
//   cmd_op              0=WRITE 1=SWAP 2=CLEAR 3=reserved
//   cmd_addr_a/b        one-hot entry selects
//   cmd_data            one-hot WRITE value
//   done, err           one-cycle completion / rejection pulses
//   rd_addr, rd_data    one-hot read select, registered read data
module key_map_table #(
    parameter int unsigned NUM_KEYS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [NUM_KEYS-1:0] cmd_addr_a,
    input  logic [NUM_KEYS-1:0] cmd_addr_b,
    input  logic [NUM_KEYS-1:0] cmd_data,
    output logic                done,
    output logic                err,
    input  logic [NUM_KEYS-1:0] rd_addr,
    output logic [NUM_KEYS-1:0] rd_data
);

    localparam int unsigned IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [NUM_KEYS-1:0] ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] LAST_K = IW'(NUM_KEYS - 1);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_SWAP  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_KEYS-1:0] r_tbl [NUM_KEYS];
    logic [1:0]          r_op;
    logic [NUM_KEYS-1:0] r_addr_a;
    logic [NUM_KEYS-1:0] r_addr_b;
    logic [NUM_KEYS-1:0] r_data;
    logic [IW-1:0]       r_clr_k;
    logic                r_cmd_ready;
    logic                r_done;
    logic                r_err;
    logic [NUM_KEYS-1:0] r_rd_data;

    logic                w_accept;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic                w_wr_en;
    logic                w_swap_en;
    logic                w_clr_en;
    logic                w_dup;
    logic [IW-1:0]       w_idx_a;
    logic [IW-1:0]       w_idx_b;

    // Position of the set bit; only meaningful when the operand is one-hot.
    function automatic logic [IW-1:0] f_idx(input logic [NUM_KEYS-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) r = IW'(i);
        end
        return r;
    endfunction

    assign w_idx_a = f_idx(r_addr_a);
    assign w_idx_b = f_idx(r_addr_b);

`ifdef KEY_MAP_PERM_CHECK_EN
    // Duplicate detection: the value already lives in some other entry.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((IW'(i) != w_idx_a) && (r_tbl[i] == r_data)) w_dup = 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, table-update strobes and completion pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr_en     = 1'b0;
        w_swap_en   = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_op == OP_CLEAR) ? S_CLEAR : S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_IDLE;
                case (r_op)
                    OP_WRITE: begin
                        if (!$onehot(r_addr_a) || !$onehot(r_data) || w_dup) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_wr_en    = 1'b1;
                            w_done_nxt = 1'b1;
                        end
                    end
                    OP_SWAP: begin
                        if (!$onehot(r_addr_a) || !$onehot(r_addr_b)) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            // a==b is a successful no-op.
                            w_swap_en  = (r_addr_a != r_addr_b);
                            w_done_nxt = 1'b1;
                        end
                    end
                    default: w_err_nxt = 1'b1;
                endcase
            end
            S_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_k == LAST_K) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, clear counter and registered handshake/pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= 2'd0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_data      <= '0;
            r_clr_k     <= '0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= cmd_op;
                r_addr_a <= cmd_addr_a;
                r_addr_b <= cmd_addr_b;
                r_data   <= cmd_data;
                r_clr_k  <= '0;
            end else if (w_clr_en) begin
                r_clr_k  <= r_clr_k + IW'(1);
            end
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Table storage; a swap exchanges both entries on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) r_tbl[i] <= ONE << i;
        end else if (w_wr_en) begin
            r_tbl[w_idx_a] <= r_data;
        end else if (w_swap_en) begin
            r_tbl[w_idx_a] <= r_tbl[w_idx_b];
            r_tbl[w_idx_b] <= r_tbl[w_idx_a];
        end else if (w_clr_en) begin
            r_tbl[r_clr_k] <= ONE << r_clr_k;
        end
    end

    // Read port; a same-edge update is not visible until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_rd_data <= '0;
        else if ($onehot(rd_addr)) r_rd_data <= r_tbl[f_idx(rd_addr)];
        else                       r_rd_data <= '0;
    end

    assign cmd_ready = r_cmd_ready;
    assign done      = r_done;
    assign err       = r_err;
    assign rd_data   = r_rd_data;

endmodule
